imm_gen_pipe: RTL and testbench

Parametrised, pipelined successor to the decode-stage immediate extender.
- Takes the full 32-bit instruction and a 3-bit format select, covering all RV formats (I/S/B/U/J), the CSR zimm and an opcode-driven auto mode.
- Sign-extends to XLEN and registers the result behind a valid/ready handshake, with an optional 2-entry skid buffer, flush and a saturating error counter.
- Sits between the fetch/decode register and the ALU operand muxes.

---
 rtl/imm_gen_pipe.sv | 153 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate extender: decodes I/S/B/U/J/zimm (or opcode-driven AUTO)
// into an XLEN-wide operand behind a valid/ready handshake with optional 2-entry skid.
module imm_gen_pipe #(
   parameter int XLEN = 32,
   parameter int SKID = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   input  logic [2:0]      imm_sel,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_out,
   output logic            fmt_err,
   output logic [7:0]      err_cnt
);

   localparam logic [2:0] FMT_I    = 3'b000;
   localparam logic [2:0] FMT_S    = 3'b001;
   localparam logic [2:0] FMT_B    = 3'b010;
   localparam logic [2:0] FMT_U    = 3'b011;
   localparam logic [2:0] FMT_J    = 3'b100;
   localparam logic [2:0] FMT_Z    = 3'b101;
   localparam logic [2:0] FMT_ERR  = 3'b110;
   localparam logic [2:0] FMT_AUTO = 3'b111;

   function automatic logic [2:0] auto_fmt(input logic [6:0] opc);
      logic [2:0] fmt;
      case (opc)
         7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: fmt = FMT_I;
         7'b0100011:             fmt = FMT_S;
         7'b1100011:             fmt = FMT_B;
         7'b0110111, 7'b0010111: fmt = FMT_U;
         7'b1101111:             fmt = FMT_J;
         default:                fmt = FMT_ERR;
      endcase
      return fmt;
   endfunction

   logic [2:0]      eff_sel;
   logic [31:0]     imm32;
   logic [XLEN-1:0] dec_imm;
   logic            dec_err;

   // Decode the offered beat into its extended immediate.
   always_comb begin
      if (imm_sel == FMT_AUTO) begin
         eff_sel = auto_fmt(inst[6:0]);
      end else begin
         eff_sel = imm_sel;
      end
      imm32   = 32'd0;
      dec_err = 1'b0;
      case (eff_sel)
         FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
         FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:   imm32 = {inst[31:12], 12'd0};
         FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         FMT_Z:   imm32 = {27'd0, inst[19:15]};
         default: dec_err = 1'b1;
      endcase
      // Zimm has bit 31 clear, so sign-extending every format is safe.
      dec_imm        = {XLEN{imm32[31]}};
      dec_imm[31:0]  = imm32;
   end

   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] out_imm_q, out_imm_d;
   logic            out_err_q, out_err_d;
   logic            skid_valid_q, skid_valid_d;
   logic [XLEN-1:0] skid_imm_q, skid_imm_d;
   logic            skid_err_q, skid_err_d;
   logic            in_ready_q, in_ready_d;
   logic [7:0]      err_cnt_q, err_cnt_d;
   logic            accept;
   logic            out_xfer;

   assign in_ready = (SKID != 0) ? in_ready_q : (!rst && (!out_valid_q || out_ready));
   assign accept   = in_valid && in_ready;
   assign out_xfer = out_valid_q && out_ready;

   // Next state of output register, skid entry, in_ready and error counter.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_err_d    = out_err_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_err_d   = skid_err_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_imm_d   = dec_imm;
            out_err_d   = dec_err;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if ((SKID != 0) && accept && !skid_valid_q) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm;
         skid_err_d   = dec_err;
      end else begin
         skid_valid_d = skid_valid_q;
      end
      in_ready_d = !skid_valid_d;
      if (out_xfer && out_err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_err_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_err_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_err_q    <= out_err_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_err_q   <= skid_err_d;
         in_ready_q   <= in_ready_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign imm_out   = out_imm_q;
   assign fmt_err   = out_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (32/skid, 64/skid, 32/no-skid) checked against
// a FIFO-of-beats reference model with arithmetic immediate extraction.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, out_ready;
   logic [31:0] inst;
   logic [2:0]  imm_sel;

   logic        rdy_a, ov_a, fe_a;
   logic [31:0] imm_a;
   logic [7:0]  ec_a;
   logic        rdy_b, ov_b, fe_b;
   logic [63:0] imm_b;
   logic [7:0]  ec_b;
   logic        rdy_c, ov_c, fe_c;
   logic [31:0] imm_c;
   logic [7:0]  ec_c;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .SKID(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .inst(inst),
      .imm_sel(imm_sel), .flush(flush), .out_valid(ov_a), .out_ready(out_ready),
      .imm_out(imm_a), .fmt_err(fe_a), .err_cnt(ec_a));
   imm_gen_pipe #(.XLEN(64), .SKID(1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .inst(inst),
      .imm_sel(imm_sel), .flush(flush), .out_valid(ov_b), .out_ready(out_ready),
      .imm_out(imm_b), .fmt_err(fe_b), .err_cnt(ec_b));
   imm_gen_pipe #(.XLEN(32), .SKID(0)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .inst(inst),
      .imm_sel(imm_sel), .flush(flush), .out_valid(ov_c), .out_ready(out_ready),
      .imm_out(imm_c), .fmt_err(fe_c), .err_cnt(ec_c));

   int          total = 0;
   int          bad = 0;
   int          which = 0;
   int          cap = 2;
   int          xl = 32;
   logic [63:0] q_imm[$];
   logic        q_err[$];
   int          m_cnt = 0;
   bit          last_acc = 1'b0;
   logic [6:0]  ops[10] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h7F};

   function automatic longint sext(input longint v, input int bits);
      longint full;
      full = longint'(1) << bits;
      if (v >= (full >> 1)) return v - full;
      return v;
   endfunction

   function automatic void ref_model(input logic [31:0] w, input logic [2:0] sel, input int xlen,
                                     output logic [63:0] imm, output logic err);
      longint u, v;
      int     f;
      u = longint'(w);
      f = int'(sel);
      err = 1'b0;
      if (f == 7) begin
         case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: f = 0;
            7'h23:        f = 1;
            7'h63:        f = 2;
            7'h37, 7'h17: f = 3;
            7'h6F:        f = 4;
            default:      f = 6;
         endcase
      end
      case (f)
         0: v = sext(u >> 20, 12);
         1: v = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
         2: v = sext(((u >> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
                     | (((u >> 8) & 15) << 1), 13);
         3: v = sext(u & 64'hFFFF_F000, 32);
         4: v = sext(((u >> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
                     | (((u >> 21) & 1023) << 1), 21);
         5: v = (u >> 15) & 31;
         default: begin v = 0; err = 1'b1; end
      endcase
      imm = 64'(v);
      if (xlen == 32) imm[63:32] = 32'd0;
   endfunction

   function automatic logic [63:0] o_imm();
      case (which)
         1: return imm_b;
         2: return {32'd0, imm_c};
         default: return {32'd0, imm_a};
      endcase
   endfunction
   function automatic logic o_valid();
      return (which == 1) ? ov_b : ((which == 2) ? ov_c : ov_a);
   endfunction
   function automatic logic o_err();
      return (which == 1) ? fe_b : ((which == 2) ? fe_c : fe_a);
   endfunction
   function automatic logic o_rdy();
      return (which == 1) ? rdy_b : ((which == 2) ? rdy_c : rdy_a);
   endfunction
   function automatic logic [7:0] o_cnt();
      return (which == 1) ? ec_b : ((which == 2) ? ec_c : ec_a);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s (dut %0d): observed=%0h expected=%0h", tag, which, obs, exp);
      end
   endtask

   // One clock: check outputs against the model mid-cycle, then advance the model.
   task automatic step();
      logic [63:0] e_imm;
      logic        e_err;
      bit          exp_rdy, acc, oxf;
      @(negedge clk);
      exp_rdy = (cap == 2) ? (q_imm.size() < 2) : (q_imm.size() == 0 || out_ready);
      chk("in_ready", 64'(o_rdy()), 64'(exp_rdy));
      chk("out_valid", 64'(o_valid()), 64'(q_imm.size() != 0));
      if (q_imm.size() != 0) begin
         chk("imm_out", o_imm(), q_imm[0]);
         chk("fmt_err", 64'(o_err()), 64'(q_err[0]));
      end
      chk("err_cnt", 64'(o_cnt()), 64'(m_cnt));
      acc = in_valid && exp_rdy;
      oxf = (q_imm.size() != 0) && out_ready;
      @(posedge clk);
      if (oxf) begin
         if (q_err[0] && m_cnt < 255) m_cnt++;
         void'(q_imm.pop_front());
         void'(q_err.pop_front());
      end
      if (flush) begin
         q_imm.delete();
         q_err.delete();
         acc = 1'b0;
      end else if (acc) begin
         ref_model(inst, imm_sel, xl, e_imm, e_err);
         q_imm.push_back(e_imm);
         q_err.push_back(e_err);
      end
      last_acc = acc;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("rst_out_valid", 64'(o_valid()), 64'd0);
      chk("rst_imm_out", o_imm(), 64'd0);
      chk("rst_fmt_err", 64'(o_err()), 64'd0);
      chk("rst_err_cnt", 64'(o_cnt()), 64'd0);
      chk("rst_in_ready", 64'(o_rdy()), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 64'(o_rdy()), 64'd1);
      q_imm.delete();
      q_err.delete();
      m_cnt = 0;
      last_acc = 1'b0;
   endtask

   task automatic phase(input int w);
      which = w;
      cap = (w == 2) ? 1 : 2;
      xl = (w == 1) ? 64 : 32;
      do_reset();
   endtask

   task automatic send(input logic [31:0] w, input logic [2:0] sel);
      int n = 0;
      inst = w; imm_sel = sel; in_valid = 1'b1;
      do begin
         step();
         n++;
      end while (!last_acc && n < 50);
      in_valid = 1'b0;
      if (!last_acc) begin
         total++;
         bad++;
         $error("FAIL accept_timeout (dut %0d): observed=not accepted expected=accepted", which);
      end
   endtask

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++) begin
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            inst = $urandom;
            imm_sel = 3'($urandom_range(0, 7));
            if (imm_sel == 3'b111 && $urandom_range(0, 3) != 0) inst[6:0] = ops[$urandom_range(0, 9)];
         end
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 39) == 0);
         if (flush) out_ready = 1'b0;
         step();
      end
      flush = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      inst = 32'd0; imm_sel = 3'd0;

      // Formats, XLEN=32
      phase(0);
      send(32'hFFF0_0093, 3'b000); chk("plan_I", o_imm(), 64'hFFFF_FFFF);
      send(32'hFE20_AE23, 3'b001); chk("plan_S", o_imm(), 64'hFFFF_FFFC);
      send(32'hFE00_0EE3, 3'b010); chk("plan_B", o_imm(), 64'hFFFF_FFFC);
      send(32'h0010_00EF, 3'b100); chk("plan_J", o_imm(), 64'h0000_0800);
      send(32'h000A_8000, 3'b101); chk("plan_Z", o_imm(), 64'h0000_0015);
      send(32'h1234_50B7, 3'b011); chk("plan_U32", o_imm(), 64'h1234_5000);
      send(32'hFE00_0EE3, 3'b111); chk("plan_autoB", o_imm(), 64'hFFFF_FFFC);
      chk("plan_autoB_err", 64'(o_err()), 64'd0);
      send(32'h0000_007F, 3'b111); chk("plan_autoBad", o_imm(), 64'd0);
      chk("plan_autoBad_err", 64'(o_err()), 64'd1);
      step(); step();

      // XLEN=64 sign extension
      phase(1);
      send(32'h8000_00B7, 3'b011); chk("plan_U64", o_imm(), 64'hFFFF_FFFF_8000_0000);
      send(32'hFFF0_0093, 3'b000); chk("plan_I64", o_imm(), 64'hFFFF_FFFF_FFFF_FFFF);
      step(); step();

      // Backpressure with skid: A, B accepted, C held, then in-order drain
      phase(0);
      out_ready = 1'b0;
      send(32'h0010_0093, 3'b000);
      send(32'h0020_0093, 3'b000);
      inst = 32'h0030_0093; imm_sel = 3'b000; in_valid = 1'b1;
      step(); step();
      chk("skid_full_in_ready", 64'(o_rdy()), 64'd0);
      out_ready = 1'b1;
      send(32'h0030_0093, 3'b000);
      step(); step(); step();

      // Backpressure without skid: only A accepted
      phase(2);
      out_ready = 1'b0;
      send(32'h0040_0093, 3'b000);
      inst = 32'h0050_0093; imm_sel = 3'b000; in_valid = 1'b1;
      step(); step();
      out_ready = 1'b1;
      send(32'h0050_0093, 3'b000);
      step(); step();

      // Error counter saturation
      phase(0);
      for (int i = 0; i < 300; i++) send($urandom, 3'b110);
      send(32'hFFF0_0093, 3'b000);
      step(); step();
      chk("err_sat", 64'(o_cnt()), 64'd255);

      // Flush with buffered beats and a concurrent offer
      phase(0);
      for (int i = 0; i < 3; i++) send($urandom, 3'b110);
      step();
      out_ready = 1'b0;
      send(32'h0060_0093, 3'b000);
      send(32'h0070_0093, 3'b110);
      flush = 1'b1; inst = 32'h0080_0093; imm_sel = 3'b000; in_valid = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("flush_cnt_kept", 64'(o_cnt()), 64'd3);
      send(32'h0090_0093, 3'b000);
      flush = 1'b1; inst = 32'h00A0_0093; in_valid = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("flush_drop_valid", 64'(o_valid()), 64'd0);

      // Reset mid-stream with full buffer and err_cnt=7
      phase(0);
      for (int i = 0; i < 7; i++) send($urandom, 3'b110);
      step();
      out_ready = 1'b0;
      send(32'h00B0_0093, 3'b000);
      send(32'h00C0_0093, 3'b000);
      step();
      chk("pre_rst_cnt", 64'(o_cnt()), 64'd7);
      do_reset();

      // Randomized traffic on each configuration
      phase(0); rand_run(400);
      phase(1); rand_run(150);
      phase(2); rand_run(150);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
